button_event_gen: RTL

Upstream input stage for the push-buttons. Takes one raw, asynchronous board switch and produces a clean debounced level plus single-cycle press, release and auto-repeat event pulses. Its outputs drive the up/down counter and edge-detect logic in the top level directly, replacing the separate debounce module and the external edge-detect registers. One instance per button.

---
 rtl/button_event_gen.sv | 124 ++++++++++++
 1 files changed

// File: rtl/button_event_gen.sv
// button_event_gen: turns one raw bouncing push-button into a debounced level
// plus single-cycle press / release / auto-repeat / event strobes.
// Chain: 2-flop synchroniser -> debounce counter -> repeat timer FSM.
module button_event_gen #(
   parameter int DEBOUNCE_CYCLES = 250000,
   parameter int REPEAT_DELAY    = 12500000,
   parameter int REPEAT_PERIOD   = 2500000
) (
   input  logic i_clk,
   input  logic i_reset,
   input  logic i_sw,
   input  logic i_repeat_en,
   output logic o_level,
   output logic o_press,
   output logic o_release,
   output logic o_repeat,
   output logic o_event
);

   localparam int CW   = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
   localparam int TW   = $clog2(RMAX + 1);

   localparam logic [CW-1:0] DB_LAST  = CW'(DEBOUNCE_CYCLES - 1);
   localparam logic [TW-1:0] T_DELAY  = TW'(REPEAT_DELAY - 1);
   localparam logic [TW-1:0] T_PERIOD = TW'(REPEAT_PERIOD - 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      HOLD   = 2'd1,
      REPEAT = 2'd2
   } state_t;

   logic          r_sync1, r_sync2;
   logic [CW-1:0] r_cnt, cnt_nxt;
   logic          level_nxt, press_nxt, release_nxt, repeat_nxt;
   state_t        r_state, state_nxt;
   logic [TW-1:0] r_timer, timer_nxt;

   // Debounce: count consecutive cycles the synchronised input disagrees
   // with the current level; any agreement restarts the count.
   always_comb begin
      cnt_nxt   = '0;
      level_nxt = o_level;
      if (r_sync2 != o_level) begin
         if (r_cnt == DB_LAST) level_nxt = ~o_level;
         else                  cnt_nxt   = r_cnt + 1'b1;
      end
   end

   assign press_nxt   =  level_nxt & ~o_level;
   assign release_nxt = ~level_nxt &  o_level;

   // Repeat FSM: keyed off the level being registered this edge, so a
   // release edge cancels any repeat due in the same cycle.
   always_comb begin
      state_nxt  = r_state;
      timer_nxt  = r_timer;
      repeat_nxt = 1'b0;
      case (r_state)
         IDLE: begin
            if (press_nxt) begin
               timer_nxt = T_DELAY;
               state_nxt = HOLD;
            end
         end
         HOLD: begin
            if (!level_nxt) begin
               state_nxt = IDLE;
            end else if (!i_repeat_en) begin
               timer_nxt = T_DELAY;
            end else if (r_timer == '0) begin
               repeat_nxt = 1'b1;
               timer_nxt  = T_PERIOD;
               state_nxt  = REPEAT;
            end else begin
               timer_nxt = r_timer - 1'b1;
            end
         end
         REPEAT: begin
            if (!level_nxt) begin
               state_nxt = IDLE;
            end else if (!i_repeat_en) begin
               timer_nxt = T_DELAY;
               state_nxt = HOLD;
            end else if (r_timer == '0) begin
               repeat_nxt = 1'b1;
               timer_nxt  = T_PERIOD;
            end else begin
               timer_nxt = r_timer - 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // State and registered outputs; reset wins over everything.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_sync1   <= 1'b0;
         r_sync2   <= 1'b0;
         r_cnt     <= '0;
         o_level   <= 1'b0;
         o_press   <= 1'b0;
         o_release <= 1'b0;
         o_repeat  <= 1'b0;
         o_event   <= 1'b0;
         r_state   <= IDLE;
         r_timer   <= '0;
      end else begin
         r_sync1   <= i_sw;
         r_sync2   <= r_sync1;
         r_cnt     <= cnt_nxt;
         o_level   <= level_nxt;
         o_press   <= press_nxt;
         o_release <= release_nxt;
         o_repeat  <= repeat_nxt;
         o_event   <= press_nxt | repeat_nxt;
         r_state   <= state_nxt;
         r_timer   <= timer_nxt;
      end
   end

endmodule
